// File: rtl/light_switch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : light_switch_ctrl
//  Description : Lamp-enable controller for the hood light. Conditions a raw
//                push-button (two-flop synchroniser, debouncer, rising-edge
//                strobe) and toggles a LIGHT_OFF/LIGHT_ON state machine on each
//                clean press. The light is forced off in hood OFF mode or after
//                an optional inactivity timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module light_switch_ctrl #(
  parameter int MODE_WIDTH      = 3,
  parameter int OFF_CODE        = 0,
  parameter int DEBOUNCE_CYCLES = 2000000,
  parameter int AUTO_OFF_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  light_btn,
  input  logic [MODE_WIDTH-1:0] current_mode,
  output logic                  islight_signal,
  output logic                  btn_pulse,
  output logic                  auto_off_pulse
);

  // Debounce counter only needs to reach DEBOUNCE_CYCLES-1.
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  // Auto-off width collapses to zero when the timer is disabled; keep one bit.
  localparam int AO_W_RAW = $clog2(AUTO_OFF_CYCLES + 1);
  localparam int AO_W     = (AO_W_RAW < 1) ? 1 : AO_W_RAW;

  localparam logic [DB_W-1:0]       DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [AO_W-1:0]       AO_LAST  = AO_W'(AUTO_OFF_CYCLES - 1);
  localparam logic [MODE_WIDTH-1:0] OFF_MODE = MODE_WIDTH'(OFF_CODE);
  localparam bit                    AO_EN    = (AUTO_OFF_CYCLES != 0);

  typedef enum logic [0:0] {
    LIGHT_OFF = 1'b0,
    LIGHT_ON  = 1'b1
  } state_t;

  logic                  sync1_q, sync1_d;
  logic                  sync2_q, sync2_d;
  logic                  btn_stable_q, btn_stable_d;
  logic [DB_W-1:0]       db_cnt_q, db_cnt_d;
  logic                  btn_pulse_q, btn_pulse_d;

  state_t                state_q, state_d;
  logic                  islight_q, islight_d;
  logic [AO_W-1:0]       ao_cnt_q, ao_cnt_d;
  logic                  auto_off_pulse_q, auto_off_pulse_d;
  logic [MODE_WIDTH-1:0] mode_prev_q, mode_prev_d;

  logic                  mode_off;
  logic                  mode_act;
  logic                  ao_expire;

  // Button conditioning: synchronise, require a run of differing samples, strobe on press.
  always_comb begin
    sync1_d      = light_btn;
    sync2_d      = sync1_q;
    btn_stable_d = btn_stable_q;
    db_cnt_d     = '0;
    btn_pulse_d  = 1'b0;
    if (sync2_q != btn_stable_q) begin
      if (db_cnt_q == DB_LAST) begin
        btn_stable_d = sync2_q;
        btn_pulse_d  = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  // Button conditioning registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      btn_stable_q <= 1'b0;
      db_cnt_q     <= '0;
      btn_pulse_q  <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      btn_stable_q <= btn_stable_d;
      db_cnt_q     <= db_cnt_d;
      btn_pulse_q  <= btn_pulse_d;
    end
  end

  assign mode_off  = (current_mode == OFF_MODE);
  assign mode_act  = (current_mode != mode_prev_q);
  // Mode activity in the expiry cycle counts as activity and wins over timeout.
  assign ao_expire = AO_EN && (ao_cnt_q == AO_LAST) && !mode_act;

  // Light FSM next state, inactivity timer and registered outputs.
  always_comb begin
    state_d          = state_q;
    ao_cnt_d         = '0;
    auto_off_pulse_d = 1'b0;
    mode_prev_d      = current_mode;
    case (state_q)
      LIGHT_OFF: begin
        if (btn_pulse_q && !mode_off) begin
          state_d = LIGHT_ON;
        end
      end
      LIGHT_ON: begin
        if (mode_off) begin
          state_d = LIGHT_OFF;
        end else if (btn_pulse_q) begin
          state_d = LIGHT_OFF;
        end else if (ao_expire) begin
          state_d          = LIGHT_OFF;
          auto_off_pulse_d = 1'b1;
        end else if (AO_EN && !mode_act) begin
          ao_cnt_d = ao_cnt_q + AO_W'(1);
        end
      end
      default: begin
        state_d = LIGHT_OFF;
      end
    endcase
    islight_d = (state_d == LIGHT_ON);
  end

  // Light FSM state and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q          <= LIGHT_OFF;
      islight_q        <= 1'b0;
      ao_cnt_q         <= '0;
      auto_off_pulse_q <= 1'b0;
      mode_prev_q      <= '0;
    end else begin
      state_q          <= state_d;
      islight_q        <= islight_d;
      ao_cnt_q         <= ao_cnt_d;
      auto_off_pulse_q <= auto_off_pulse_d;
      mode_prev_q      <= mode_prev_d;
    end
  end

  assign islight_signal = islight_q;
  assign btn_pulse      = btn_pulse_q;
  assign auto_off_pulse = auto_off_pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_light_switch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_light_switch_ctrl
//  Description : Self-checking bench for light_switch_ctrl with a behavioural
//                reference model (sample history + timestamps) and directed
//                literal checks followed by randomized stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_light_switch_ctrl;

  localparam int DB = 4;
  localparam int AO = 20;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       light_btn = 1'b0;
  logic [2:0] current_mode = 3'd1;
  logic       islight_signal, btn_pulse, auto_off_pulse;

  int checks = 0;
  int failures = 0;

  light_switch_ctrl #(
    .MODE_WIDTH(3), .OFF_CODE(0), .DEBOUNCE_CYCLES(DB), .AUTO_OFF_CYCLES(AO)
  ) dut (
    .clk(clk), .rstn(rstn), .light_btn(light_btn), .current_mode(current_mode),
    .islight_signal(islight_signal), .btn_pulse(btn_pulse), .auto_off_pulse(auto_off_pulse)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  bit         m_s1, m_s2, m_stable, m_pulse, m_on, m_aop;
  bit         hist [DB];      // most recent synchronised samples, [0] newest
  int         nhist;
  logic [2:0] m_prev;
  int         edge_n, last_act;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_s1 = 0; m_s2 = 0; m_stable = 0; m_pulse = 0; m_on = 0; m_aop = 0;
      nhist = 0; m_prev = '0; edge_n = 0; last_act = 0;
    end else begin
      bit all_diff;
      edge_n++;
      m_aop = 0;
      // Lamp: toggle on registered press, forced off by OFF mode, timeout
      // measured as edges elapsed since the last entry or mode activity.
      if (!m_on) begin
        if (m_pulse && current_mode != 3'd0) begin
          m_on = 1; last_act = edge_n;
        end
      end else if (current_mode == 3'd0 || m_pulse) begin
        m_on = 0;
      end else if (current_mode != m_prev) begin
        last_act = edge_n;
      end else if (edge_n - last_act == AO) begin
        m_on = 0; m_aop = 1;
      end
      m_prev = current_mode;
      // Debounce: accept a level once the last DB synchronised samples all differ.
      for (int i = DB - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = m_s2;
      if (nhist < DB) nhist++;
      all_diff = (nhist == DB);
      for (int i = 0; i < DB; i++) if (hist[i] == m_stable) all_diff = 0;
      m_pulse = 0;
      if (all_diff) begin
        m_stable = m_s2; m_pulse = m_s2; nhist = 0;
      end
      m_s2 = m_s1;
      m_s1 = light_btn;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rstn) begin
      checks++;
      if (islight_signal !== m_on || btn_pulse !== m_pulse || auto_off_pulse !== m_aop) begin
        failures++;
        $display("FAIL model t=%0t got light=%b pulse=%b aop=%b expected light=%b pulse=%b aop=%b",
                 $time, islight_signal, btn_pulse, auto_off_pulse, m_on, m_pulse, m_aop);
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive a press and count negedges until btn_pulse is seen.
  task automatic press_latency(output int lat);
    light_btn = 1'b1;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (btn_pulse) break;
    end
  endtask

  task automatic wait_light(input bit val, output bit ok);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (islight_signal == val) begin ok = 1; break; end
    end
  endtask

  // Count negedges with the light on, starting at the first on sample.
  task automatic count_on(input int mode_chg_at, output int on_cnt, output bit aop_at_fall);
    on_cnt = 1;
    aop_at_fall = 0;
    for (int i = 0; i < 80; i++) begin
      if (on_cnt == mode_chg_at) current_mode = 3'd2;
      @(negedge clk);
      if (!islight_signal) begin aop_at_fall = auto_off_pulse; break; end
      on_cnt++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat, on_cnt, pulses;
    bit  ok, aopf;
    bit  bounce [5];
    bounce[0] = 1; bounce[1] = 0; bounce[2] = 1; bounce[3] = 0; bounce[4] = 1;

    // Reset state
    idle(3);
    chk("reset_light", islight_signal, 0);
    chk("reset_pulse", btn_pulse, 0);
    chk("reset_aop", auto_off_pulse, 0);
    rstn = 1'b1;
    idle(3);

    // 1: clean press, exact latency, release, re-press toggles off
    current_mode = 3'd1;
    press_latency(lat);
    chk("press_latency", lat, DB + 2);
    @(negedge clk);
    chk("light_on_after_pulse", islight_signal, 1);
    chk("pulse_one_cycle", btn_pulse, 0);
    light_btn = 1'b0;
    idle(10);
    chk("release_no_toggle", islight_signal, 1);
    press_latency(lat);
    @(negedge clk);
    chk("repress_off", islight_signal, 0);
    light_btn = 1'b0;
    idle(10);

    // 2: bounce shorter than the debounce window
    foreach (bounce[i]) begin light_btn = bounce[i]; @(negedge clk); end
    light_btn = 1'b0;
    pulses = 0;
    repeat (12) begin @(negedge clk); if (btn_pulse) pulses++; end
    chk("bounce_no_pulse", pulses, 0);
    chk("bounce_light_off", islight_signal, 0);

    // 3: press ignored in OFF mode; on in mode 2; OFF mode forces off
    current_mode = 3'd0;
    idle(2);
    light_btn = 1'b1; idle(10); light_btn = 1'b0; idle(10);
    chk("off_mode_press_ignored", islight_signal, 0);
    current_mode = 3'd2;
    idle(2);
    press_latency(lat);
    @(negedge clk);
    chk("mode2_light_on", islight_signal, 1);
    light_btn = 1'b0;
    idle(3);
    current_mode = 3'd0;
    @(negedge clk);
    chk("mode_off_forces_off", islight_signal, 0);
    chk("mode_off_no_aop", auto_off_pulse, 0);
    idle(10);

    // 4: auto-off after 20 cycles; mode change at cycle 15 restarts count
    current_mode = 3'd1;
    idle(2);
    light_btn = 1'b1;
    wait_light(1, ok);
    chk("ao_light_on", ok, 1);
    light_btn = 1'b0;
    count_on(0, on_cnt, aopf);
    chk("ao_on_cycles", on_cnt, AO);
    chk("ao_pulse_at_fall", aopf, 1);
    idle(8);
    light_btn = 1'b1;
    wait_light(1, ok);
    light_btn = 1'b0;
    count_on(15, on_cnt, aopf);
    chk("ao_restart_cycles", on_cnt, 15 + AO);
    chk("ao_restart_pulse", aopf, 1);
    idle(8);

    // 5: press and OFF mode in the same cycle -> single transition to off
    current_mode = 3'd1;
    idle(2);
    light_btn = 1'b1;
    wait_light(1, ok);
    light_btn = 1'b0;
    idle(6);
    press_latency(lat);
    current_mode = 3'd0;
    @(negedge clk);
    chk("press_and_off_light", islight_signal, 0);
    light_btn = 1'b0;
    idle(10);
    chk("press_and_off_no_retoggle", islight_signal, 0);

    // 6: reset mid-ON and mid-debounce
    current_mode = 3'd1;
    idle(2);
    light_btn = 1'b1;
    wait_light(1, ok);
    light_btn = 1'b0;
    idle(6);
    light_btn = 1'b1;
    idle(4);
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_light", islight_signal, 0);
    chk("async_rst_pulse", btn_pulse, 0);
    chk("async_rst_aop", auto_off_pulse, 0);
    @(negedge clk);
    #2 rstn = 1'b1;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (btn_pulse) break;
    end
    chk("post_reset_full_debounce", lat, DB + 2);
    light_btn = 1'b0;
    idle(10);

    // Randomized stimulus, checked every cycle by the model
    for (int i = 0; i < 500; i++) begin
      light_btn = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) current_mode = 3'($urandom_range(0, 3));
      repeat ($urandom_range(1, 9)) @(negedge clk);
    end
    light_btn = 1'b0;
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
